// File: rtl/ramp_sequencer_if.sv
// rtl/ramp_sequencer_if.sv - control and sample bundle for the ramp sequencer
interface ramp_sequencer_if #(
  parameter int WIDTH = 5
);
  logic             enable;
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] out;
  logic             dir;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output enable, start, stop, mode, limit, step,
    input  out, dir, busy, done, wrap
  );

  modport slave (
    input  enable, start, stop, mode, limit, step,
    output out, dir, busy, done, wrap
  );
endinterface

// File: rtl/ramp_sequencer.sv
// rtl/ramp_sequencer.sv - programmable up/down ramp generator, one sample per enabled tick
module ramp_sequencer #(
  parameter int WIDTH            = 5,
  parameter bit ZERO_STEP_AS_ONE = 1'b1
) (
  input  logic              tick,
  input  logic              reset,
  ramp_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  localparam logic [1:0] MODE_DOWN1 = 2'd0;
  localparam logic [1:0] MODE_SAW   = 2'd1;
  localparam logic [1:0] MODE_TRI   = 2'd2;
  localparam logic [1:0] MODE_TRI1  = 2'd3;

  state_t           state;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] step_q;
  logic [1:0]       mode_q;
  logic             dir_q;
  logic             busy_q;
  logic             done_q;
  logic             wrap_q;

  logic [WIDTH-1:0] step_eff;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] down_val;
  logic             one_shot;

  // Saturating next values for an up or down step; the extra bit keeps Out+Step from wrapping
  always_comb begin
    step_eff = step_q;
    if (ZERO_STEP_AS_ONE && (step_q == '0)) begin
      step_eff = WIDTH'(1);
    end
    up_sum   = {1'b0, out_q} + {1'b0, step_eff};
    up_val   = (up_sum >= {1'b0, limit_q}) ? limit_q : up_sum[WIDTH-1:0];
    down_val = (out_q <= step_eff) ? '0 : (out_q - step_eff);
    one_shot = (mode_q == MODE_DOWN1) || (mode_q == MODE_TRI1);
  end

  // Ramp FSM: stop beats start beats stepping; status pulses last one enabled cycle
  always_ff @(posedge tick or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      out_q   <= '0;
      dir_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      mode_q  <= '0;
      limit_q <= '0;
      step_q  <= '0;
    end else if (!bus.enable) begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (bus.stop) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else if (bus.start) begin
        mode_q  <= bus.mode;
        limit_q <= bus.limit;
        step_q  <= bus.step;
        busy_q  <= 1'b1;
        if (bus.mode == MODE_DOWN1) begin
          out_q <= bus.limit;
          dir_q <= 1'b0;
          state <= DOWN;
        end else begin
          out_q <= '0;
          dir_q <= 1'b1;
          state <= UP;
        end
      end else begin
        case (state)
          UP: begin
            if (out_q < limit_q) begin
              out_q <= up_val;
            end else if (mode_q == MODE_SAW) begin
              out_q  <= '0;
              wrap_q <= 1'b1;
            end else begin
              // Peak has dwelt one cycle; turn around with a down step
              out_q <= down_val;
              dir_q <= 1'b0;
              state <= DOWN;
              if (down_val == '0) begin
                if (one_shot) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
                end else begin
                  wrap_q <= 1'b1;
                end
              end
            end
          end
          DOWN: begin
            if (out_q != '0) begin
              out_q <= down_val;
              if (down_val == '0) begin
                if (one_shot) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
                end else begin
                  wrap_q <= 1'b1;
                end
              end
            end else if (one_shot) begin
              // Only reachable when DOWN1 was loaded with a zero limit
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              // Valley of a continuous triangle: climb again
              out_q  <= up_val;
              dir_q  <= 1'b1;
              state  <= UP;
              wrap_q <= (up_val == '0);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.out  = out_q;
  assign bus.dir  = dir_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_ramp_sequencer.sv
// tb/tb_ramp_sequencer.sv - self-checking bench for ramp_sequencer against a list-based ramp model
module tb_ramp_sequencer;

  logic tick = 1'b0;
  logic reset;

  ramp_sequencer_if #(.WIDTH(5)) bus ();

  ramp_sequencer #(.WIDTH(5), .ZERO_STEP_AS_ONE(1'b1)) dut (
    .tick  (tick),
    .reset (reset),
    .bus   (bus)
  );

  always #5 tick = ~tick;

  typedef struct {
    logic [4:0] out;
    logic       dir;
    logic       busy;
    logic       done;
    logic       wrap;
  } samp_t;

  int    passed = 0;
  int    total  = 0;
  samp_t run_q[$];
  samp_t e;
  int    idx;
  bit    active;

  function automatic void push(int v, logic d, logic dn, logic w, logic b);
    samp_t s;
    s.out  = 5'(v);
    s.dir  = d;
    s.done = dn;
    s.wrap = w;
    s.busy = b;
    run_q.push_back(s);
  endfunction

  // Whole expected waveform of one run, built from the up/down value ladders
  function automatic void build_run(int m, int lim, int stp);
    int s;
    int v;
    int k;
    int ups[$];
    int downs[$];
    run_q.delete();
    s = (stp == 0) ? 1 : stp;
    k = 0;
    do begin
      v = (k * s < lim) ? k * s : lim;
      ups.push_back(v);
      k++;
    end while (v != lim);
    k = 1;
    do begin
      v = (lim - k * s > 0) ? lim - k * s : 0;
      downs.push_back(v);
      k++;
    end while (v != 0);
    case (m)
      0: begin
        push(lim, 1'b0, 1'b0, 1'b0, 1'b1);
        foreach (downs[i]) push(downs[i], 1'b0, i == downs.size() - 1, 1'b0, i != downs.size() - 1);
      end
      3: begin
        foreach (ups[i]) push(ups[i], 1'b1, 1'b0, 1'b0, 1'b1);
        foreach (downs[i]) push(downs[i], 1'b0, i == downs.size() - 1, 1'b0, i != downs.size() - 1);
      end
      1: begin
        push(0, 1'b1, 1'b0, 1'b0, 1'b1);
        while (run_q.size() < 600) begin
          for (int i = 1; i < ups.size(); i++) push(ups[i], 1'b1, 1'b0, 1'b0, 1'b1);
          push(0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
      end
      default: begin
        foreach (ups[i]) push(ups[i], 1'b1, 1'b0, 1'b0, 1'b1);
        while (run_q.size() < 600) begin
          foreach (downs[i]) push(downs[i], 1'b0, 1'b0, downs[i] == 0, 1'b1);
          if (ups.size() == 1) push(0, 1'b1, 1'b0, 1'b1, 1'b1);
          else for (int i = 1; i < ups.size(); i++) push(ups[i], 1'b1, 1'b0, 1'b0, 1'b1);
        end
      end
    endcase
  endfunction

  function automatic void model_reset();
    e.out = 5'd0; e.dir = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.wrap = 1'b0;
    active = 1'b0;
    idx = 0;
  endfunction

  function automatic void model_edge(bit en, bit st, bit sp, int md, int lim, int stp);
    if (!en) begin
      e.done = 1'b0; e.wrap = 1'b0;
    end else if (sp) begin
      e.busy = 1'b0; e.done = 1'b0; e.wrap = 1'b0;
      active = 1'b0;
    end else if (st) begin
      build_run(md, lim, stp);
      idx = 0;
      e = run_q[0];
      active = 1'b1;
    end else if (active && (idx + 1 < run_q.size())) begin
      idx++;
      e = run_q[idx];
      if (e.done) active = 1'b0;
    end else begin
      e.done = 1'b0; e.wrap = 1'b0;
    end
  endfunction

  function automatic logic [8:0] pack_dut();
    return {bus.out, bus.dir, bus.busy, bus.done, bus.wrap};
  endfunction

  function automatic logic [8:0] pack_exp();
    return {e.out, e.dir, e.busy, e.done, e.wrap};
  endfunction

  task automatic drive(input bit en, input bit st, input bit sp, input int md, input int lim, input int stp);
    @(negedge tick);
    bus.enable = en;
    bus.start  = st;
    bus.stop   = sp;
    bus.mode   = 2'(md);
    bus.limit  = 5'(lim);
    bus.step   = 5'(stp);
    model_edge(en, st, sp, md, lim, stp);
    @(posedge tick);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (pack_dut() !== 9'b00000_1_0_0_0) $display("FAIL reset_state: got %b want %b", pack_dut(), 9'b00000_1_0_0_0);
    else passed++;
    @(negedge tick);
    reset = 1'b0;
    drive(1, 1, 0, 1, 20, 1);
    repeat (13) drive(1, 0, 0, 1, 20, 1);
    total++;
    if (bus.out !== 5'd13) $display("FAIL reset_pre_out: got %0d want 13", bus.out);
    else passed++;
    #2 reset = 1'b1;
    #1;
    model_reset();
    total++;
    if (pack_dut() !== pack_exp()) $display("FAIL reset_async: got %b want %b", pack_dut(), pack_exp());
    else passed++;
    #1 reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    total++;
    if (pack_dut() !== pack_exp()) $display("FAIL reset_idle: got %b want %b", pack_dut(), pack_exp());
    else passed++;
  endtask

  task automatic test_down1();
    int dones;
    dones = 0;
    for (int i = 0; i <= 31; i++) begin
      drive(1, i == 0, 0, 0, (i == 0) ? 31 : int'($urandom_range(31)), (i == 0) ? 1 : int'($urandom_range(31)));
      if (bus.done === 1'b1) dones++;
      total++;
      if (pack_dut() !== pack_exp() || bus.out !== 5'(31 - i))
        $display("FAIL down1_edge%0d: got %b want %b (out %0d)", i, pack_dut(), pack_exp(), 31 - i);
      else passed++;
    end
    drive(1, 0, 0, 0, 5, 5);
    total++;
    if (dones != 1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 5'd0)
      $display("FAIL down1_final: got dones=%0d busy=%b done=%b out=%0d want 1 0 0 0", dones, bus.busy, bus.done, bus.out);
    else passed++;
  endtask

  task automatic test_saw();
    int so[9];
    so = '{0, 4, 8, 10, 0, 4, 8, 10, 0};
    for (int i = 0; i < 9; i++) begin
      drive(1, i == 0, 0, 1, 10, 4);
      total++;
      if (bus.out !== 5'(so[i]) || bus.wrap !== (i > 0 && so[i] == 0) || pack_dut() !== pack_exp())
        $display("FAIL saw_edge%0d: got %b want out=%0d model %b", i, pack_dut(), so[i], pack_exp());
      else passed++;
    end
  endtask

  task automatic test_tri1();
    int to[7];
    int td[7];
    to = '{0, 3, 6, 9, 6, 3, 0};
    td = '{1, 1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      drive(1, i == 0, 0, 3, 9, 3);
      total++;
      if (bus.out !== 5'(to[i]) || bus.dir !== td[i][0] || bus.done !== (i == 6) || bus.wrap !== 1'b0)
        $display("FAIL tri1_edge%0d: got %b want out=%0d dir=%0d done=%0d", i, pack_dut(), to[i], td[i], i == 6);
      else passed++;
    end
    drive(1, 0, 0, 3, 9, 3);
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 5'd0)
      $display("FAIL tri1_after: got %b want busy=0 done=0 out=0", pack_dut());
    else passed++;
  endtask

  task automatic test_stop_start();
    drive(1, 1, 0, 2, 15, 2);
    repeat (5) drive(1, 0, 0, 2, 15, 2);
    drive(1, 1, 1, 0, 7, 1);
    total++;
    if (bus.out !== 5'd10 || bus.busy !== 1'b0 || bus.dir !== 1'b1 || pack_dut() !== pack_exp())
      $display("FAIL stop_start: got %b want out=10 dir=1 busy=0 model %b", pack_dut(), pack_exp());
    else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 7, 1);
      total++;
      if (pack_dut() !== pack_exp()) $display("FAIL stop_hold%0d: got %b want %b", i, pack_dut(), pack_exp());
      else passed++;
    end
  endtask

  task automatic test_enable_freeze();
    drive(1, 1, 0, 1, 6, 2);
    repeat (3) drive(1, 0, 0, 1, 6, 2);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 31, 1);
      total++;
      if (bus.out !== 5'd6 || bus.wrap !== 1'b0 || pack_dut() !== pack_exp())
        $display("FAIL enable_low%0d: got %b want out=6 wrap=0", i, pack_dut());
      else passed++;
    end
    drive(1, 0, 0, 1, 6, 2);
    total++;
    if (bus.out !== 5'd0 || bus.wrap !== 1'b1 || pack_dut() !== pack_exp())
      $display("FAIL enable_resume_wrap: got %b want out=0 wrap=1", pack_dut());
    else passed++;
    drive(1, 0, 0, 1, 6, 2);
    total++;
    if (bus.out !== 5'd2 || bus.wrap !== 1'b0 || pack_dut() !== pack_exp())
      $display("FAIL enable_resume_step: got %b want out=2 wrap=0", pack_dut());
    else passed++;
  endtask

  task automatic test_zero_step();
    int zo[7];
    zo = '{0, 1, 2, 3, 4, 5, 0};
    for (int i = 0; i < 7; i++) begin
      drive(1, i == 0, 0, 1, 5, 0);
      total++;
      if (bus.out !== 5'(zo[i]) || pack_dut() !== pack_exp())
        $display("FAIL zero_step_edge%0d: got %b want out=%0d", i, pack_dut(), zo[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    bit en, st, sp;
    int md, lim, stp;
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(99) < 85);
      st  = ($urandom_range(99) < 8);
      sp  = ($urandom_range(99) < 4);
      md  = int'($urandom_range(3));
      lim = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(31));
      stp = ($urandom_range(3) == 0) ? int'($urandom_range(31)) : int'($urandom_range(4));
      drive(en, st, sp, md, lim, stp);
      total++;
      if (pack_dut() !== pack_exp())
        $display("FAIL random_edge%0d: got %b want %b (en=%0d st=%0d sp=%0d)", i, pack_dut(), pack_exp(), en, st, sp);
      else passed++;
    end
  endtask

  initial begin
    reset      = 1'b0;
    bus.enable = 1'b0;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.mode   = 2'd0;
    bus.limit  = 5'd0;
    bus.step   = 5'd0;
    model_reset();
    #1 reset = 1'b1;
    test_reset();
    test_down1();
    test_saw();
    test_tri1();
    test_stop_start();
    test_enable_freeze();
    test_zero_step();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
